// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - shared types, limits and BCD range check for time_of_day
package time_pkg;

    typedef logic [7:0] bcd_t;

    localparam bcd_t SEC_MAX = 8'h59;
    localparam bcd_t MIN_MAX = 8'h59;

    typedef enum logic {
        RUN   = 1'b0,
        CHECK = 1'b1
    } state_t;

    // Both digits must be decimal before the packed value can be range-compared.
    function automatic logic bcd_ok(input bcd_t value, input bcd_t max_val);
        return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max_val);
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// rtl/bcd2_counter.sv - two-digit BCD mod-N counter with load and carry-out
module bcd2_counter
    import time_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic load,
    input  bcd_t load_val,
    input  bcd_t max_val,
    output bcd_t value,
    output logic carry
);

    bcd_t value_next;
    logic at_max;

    assign at_max = (value == max_val);
    assign carry  = en && at_max;

    always_comb begin
        value_next = value;
        if (load) begin
            value_next = load_val;
        end else if (en) begin
            if (at_max) begin
                value_next = 8'h00;
            end else if (value[3:0] == 4'd9) begin
                value_next = {value[7:4] + 4'd1, 4'h0};
            end else begin
                value_next = {value[7:4], value[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= 8'h00;
        end else begin
            value <= value_next;
        end
    end

endmodule

// File: rtl/time_of_day.sv
// rtl/time_of_day.sv - BCD time-of-day counter with checked set; alarm under ALARM_EN
module time_of_day
    import time_pkg::*;
#(
    parameter bcd_t HOURS_MAX          = 8'h23,
    parameter int   TICK_PENDING_DEPTH = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_1s,
    input  logic        set_valid,
    input  logic [23:0] set_time,
    output logic        set_ready,
    output logic        set_err,
    output logic [7:0]  hh,
    output logic [7:0]  mm,
    output logic [7:0]  ss,
`ifdef ALARM_EN
    input  logic [15:0] alarm_time,
    input  logic        alarm_arm,
    input  logic        alarm_ack,
    output logic        alarm,
`endif
    output logic        min_pulse
);

    state_t      state;
    state_t      next_state;
    logic [23:0] shadow;
    logic        pending;
    logic        shadow_ok;
    logic        accept;
    logic        load;
    logic        reject;
    logic        run_tick;
    logic        ss_carry;
    logic        mm_carry;
    logic        hh_carry;

    assign shadow_ok = bcd_ok(shadow[7:0],   SEC_MAX)
                    && bcd_ok(shadow[15:8],  MIN_MAX)
                    && bcd_ok(shadow[23:16], HOURS_MAX);

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        load       = 1'b0;
        reject     = 1'b0;
        run_tick   = 1'b0;
        case (state)
            RUN: begin
                // A tick held over from CHECK merges with a fresh one.
                run_tick = tick_1s || pending;
                if (set_valid && set_ready) begin
                    accept     = 1'b1;
                    next_state = CHECK;
                end
            end
            CHECK: begin
                next_state = RUN;
                if (shadow_ok) begin
                    load = 1'b1;
                end else begin
                    reject = 1'b1;
                end
            end
            default: next_state = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            shadow    <= 24'h000000;
            pending   <= 1'b0;
            set_ready <= 1'b1;
            set_err   <= 1'b0;
            min_pulse <= 1'b0;
        end else begin
            state     <= next_state;
            set_ready <= (next_state == RUN);
            set_err   <= reject;
            min_pulse <= ss_carry;
            if (accept) begin
                shadow <= set_time;
            end
            if (state == CHECK) begin
                pending <= !load && tick_1s && (TICK_PENDING_DEPTH > 0);
            end else begin
                pending <= 1'b0;
            end
        end
    end

    bcd2_counter u_ss (
        .clk      (clk),
        .reset    (reset),
        .en       (run_tick),
        .load     (load),
        .load_val (shadow[7:0]),
        .max_val  (SEC_MAX),
        .value    (ss),
        .carry    (ss_carry)
    );

    bcd2_counter u_mm (
        .clk      (clk),
        .reset    (reset),
        .en       (ss_carry),
        .load     (load),
        .load_val (shadow[15:8]),
        .max_val  (MIN_MAX),
        .value    (mm),
        .carry    (mm_carry)
    );

    bcd2_counter u_hh (
        .clk      (clk),
        .reset    (reset),
        .en       (mm_carry),
        .load     (load),
        .load_val (shadow[23:16]),
        .max_val  (HOURS_MAX),
        .value    (hh),
        .carry    (hh_carry)
    );

    logic unused_carry;
    assign unused_carry = hh_carry;

`ifdef ALARM_EN
    logic alarm_hit;

    // ss reads 00 after a tick only via a wrap, so min_pulse marks tick-driven minute starts.
    assign alarm_hit = min_pulse && alarm_arm && ({hh, mm} == alarm_time);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alarm <= 1'b0;
        end else if (alarm_hit) begin
            alarm <= 1'b1;
        end else if (alarm_ack || !alarm_arm) begin
            alarm <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_time_of_day.sv
// tb/tb_time_of_day.sv - directed self-checking bench for time_of_day
module tb_time_of_day;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_1s;
    logic        set_valid;
    logic [23:0] set_time;
    logic        set_ready;
    logic        set_err;
    logic [7:0]  hh;
    logic [7:0]  mm;
    logic [7:0]  ss;
    logic        min_pulse;
`ifdef ALARM_EN
    logic [15:0] alarm_time;
    logic        alarm_arm;
    logic        alarm_ack;
    logic        alarm;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    time_of_day dut (
        .clk        (clk),
        .reset      (reset),
        .tick_1s    (tick_1s),
        .set_valid  (set_valid),
        .set_time   (set_time),
        .set_ready  (set_ready),
        .set_err    (set_err),
        .hh         (hh),
        .mm         (mm),
        .ss         (ss),
`ifdef ALARM_EN
        .alarm_time (alarm_time),
        .alarm_arm  (alarm_arm),
        .alarm_ack  (alarm_ack),
        .alarm      (alarm),
`endif
        .min_pulse  (min_pulse)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_set(input logic [23:0] t);
        set_valid = 1'b1;
        set_time  = t;
        cyc();
        set_valid = 1'b0;
        checks++;
        if (set_ready !== 1'b0) begin
            errors++;
            $display("FAIL set_ready_in_check: got %b expected 0", set_ready);
        end
        cyc();
        checks++;
        if ({hh, mm, ss, set_ready, set_err} !== {t, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL load %h: got %h%h%h ready %b err %b expected %h ready 1 err 0",
                     t, hh, mm, ss, set_ready, set_err, t);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cyc();
        cyc();
        checks++;
        if ({hh, mm, ss, set_ready, set_err, min_pulse} !== {24'h000000, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got %h%h%h ready %b err %b mp %b expected 000000 1 0 0",
                     hh, mm, ss, set_ready, set_err, min_pulse);
        end
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            checks++;
            if ({hh, mm, ss, min_pulse} !== {24'h000000, 1'b0}) begin
                errors++;
                $display("FAIL idle_after_reset: got %h%h%h mp %b expected 000000 mp 0",
                         hh, mm, ss, min_pulse);
            end
        end
    endtask

    task automatic test_wrap();
        do_set(24'h235959);
        checks++;
        if (min_pulse !== 1'b0) begin
            errors++;
            $display("FAIL load_no_min_pulse: got %b expected 0", min_pulse);
        end
        tick_1s = 1'b1;
        cyc();
        tick_1s = 1'b0;
        checks++;
        if ({hh, mm, ss, min_pulse} !== {24'h000000, 1'b1}) begin
            errors++;
            $display("FAIL day_wrap: got %h%h%h mp %b expected 000000 mp 1", hh, mm, ss, min_pulse);
        end
        cyc();
        checks++;
        if ({hh, mm, ss, min_pulse} !== {24'h000000, 1'b0}) begin
            errors++;
            $display("FAIL min_pulse_one_cycle: got %h%h%h mp %b expected 000000 mp 0",
                     hh, mm, ss, min_pulse);
        end
    endtask

    task automatic test_increment();
        logic [23:0] start_v [3];
        logic [23:0] exp_v   [3];
        logic        exp_mp  [3];
        start_v = '{24'h000009, 24'h135959, 24'h095959};
        exp_v   = '{24'h000010, 24'h140000, 24'h100000};
        exp_mp  = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            do_set(start_v[i]);
            tick_1s = 1'b1;
            cyc();
            tick_1s = 1'b0;
            checks++;
            if ({hh, mm, ss, min_pulse} !== {exp_v[i], exp_mp[i]}) begin
                errors++;
                $display("FAIL increment %h: got %h%h%h mp %b expected %h mp %b",
                         start_v[i], hh, mm, ss, min_pulse, exp_v[i], exp_mp[i]);
            end
        end
    endtask

    task automatic test_reject();
        logic [23:0] bad [6];
        bad = '{24'h245900, 24'h125A00, 24'h006000, 24'h000060, 24'h0A0000, 24'h00000F};
        do_set(24'h082000);
        for (int i = 0; i < 6; i++) begin
            set_valid = 1'b1;
            set_time  = bad[i];
            cyc();
            set_valid = 1'b0;
            checks++;
            if ({set_ready, set_err} !== 2'b00) begin
                errors++;
                $display("FAIL reject_check_cycle %h: got ready %b err %b expected 0 0",
                         bad[i], set_ready, set_err);
            end
            cyc();
            checks++;
            if ({hh, mm, ss, set_ready, set_err} !== {24'h082000, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL reject %h: got %h%h%h ready %b err %b expected 082000 1 1",
                         bad[i], hh, mm, ss, set_ready, set_err);
            end
            cyc();
            checks++;
            if (set_err !== 1'b0) begin
                errors++;
                $display("FAIL set_err_one_cycle %h: got %b expected 0", bad[i], set_err);
            end
        end
    endtask

    task automatic test_tick_during_set();
        do_set(24'h050000);
        set_valid = 1'b1;
        set_time  = 24'h100000;
        tick_1s   = 1'b1;
        cyc();
        set_valid = 1'b0;
        checks++;
        if ({hh, mm, ss} !== 24'h050001) begin
            errors++;
            $display("FAIL tick_in_accept: got %h%h%h expected 050001", hh, mm, ss);
        end
        cyc();
        tick_1s = 1'b0;
        checks++;
        if ({hh, mm, ss, set_err} !== {24'h100000, 1'b0}) begin
            errors++;
            $display("FAIL load_over_tick: got %h%h%h err %b expected 100000 0", hh, mm, ss, set_err);
        end
        cyc();
        cyc();
        checks++;
        if ({hh, mm, ss} !== 24'h100000) begin
            errors++;
            $display("FAIL pending_cleared_by_load: got %h%h%h expected 100000", hh, mm, ss);
        end
    endtask

    task automatic test_reject_pending();
        // Pending tick merged with a fresh tick in the first RUN cycle.
        set_valid = 1'b1;
        set_time  = 24'h995900;
        cyc();
        set_valid = 1'b0;
        tick_1s   = 1'b1;
        cyc();
        checks++;
        if ({hh, mm, ss, set_err} !== {24'h100000, 1'b1}) begin
            errors++;
            $display("FAIL reject_with_tick: got %h%h%h err %b expected 100000 1", hh, mm, ss, set_err);
        end
        cyc();
        tick_1s = 1'b0;
        checks++;
        if ({hh, mm, ss} !== 24'h100001) begin
            errors++;
            $display("FAIL pending_merge: got %h%h%h expected 100001", hh, mm, ss);
        end
        cyc();
        checks++;
        if ({hh, mm, ss} !== 24'h100001) begin
            errors++;
            $display("FAIL pending_merge_settle: got %h%h%h expected 100001", hh, mm, ss);
        end
        // Pending tick alone.
        set_valid = 1'b1;
        set_time  = 24'h006000;
        cyc();
        set_valid = 1'b0;
        tick_1s   = 1'b1;
        cyc();
        tick_1s = 1'b0;
        checks++;
        if ({hh, mm, ss} !== 24'h100001) begin
            errors++;
            $display("FAIL pending_held: got %h%h%h expected 100001", hh, mm, ss);
        end
        cyc();
        cyc();
        checks++;
        if ({hh, mm, ss} !== 24'h100002) begin
            errors++;
            $display("FAIL pending_applied: got %h%h%h expected 100002", hh, mm, ss);
        end
    endtask

    task automatic test_back_to_back();
        do_set(24'h012345);
        do_set(24'h230000);
        do_set(24'h000000);
    endtask

    task automatic test_reset_mid_check();
        do_set(24'h111111);
        set_valid = 1'b1;
        set_time  = 24'h120000;
        cyc();
        set_valid = 1'b0;
        reset     = 1'b0;
        #2;
        checks++;
        if ({hh, mm, ss, set_ready, set_err} !== {24'h000000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got %h%h%h ready %b err %b expected 000000 1 0",
                     hh, mm, ss, set_ready, set_err);
        end
        cyc();
        reset = 1'b1;
        cyc();
        cyc();
        checks++;
        if ({hh, mm, ss, set_ready, set_err} !== {24'h000000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL set_discarded: got %h%h%h ready %b err %b expected 000000 1 0",
                     hh, mm, ss, set_ready, set_err);
        end
    endtask

`ifdef ALARM_EN
    task automatic test_alarm();
        alarm_time = 16'h0730;
        alarm_arm  = 1'b1;
        do_set(24'h072959);
        tick_1s = 1'b1;
        cyc();
        tick_1s = 1'b0;
        cyc();
        checks++;
        if (alarm !== 1'b1) begin
            errors++;
            $display("FAIL alarm_set: got %b expected 1", alarm);
        end
        alarm_ack = 1'b1;
        cyc();
        alarm_ack = 1'b0;
        checks++;
        if (alarm !== 1'b0) begin
            errors++;
            $display("FAIL alarm_ack: got %b expected 0", alarm);
        end
        do_set(24'h073000);
        cyc();
        cyc();
        checks++;
        if (alarm !== 1'b0) begin
            errors++;
            $display("FAIL alarm_on_load: got %b expected 0", alarm);
        end
    endtask
`endif

    initial begin
        reset     = 1'b0;
        tick_1s   = 1'b0;
        set_valid = 1'b0;
        set_time  = 24'h000000;
`ifdef ALARM_EN
        alarm_time = 16'h0000;
        alarm_arm  = 1'b0;
        alarm_ack  = 1'b0;
`endif
        test_reset();
        test_wrap();
        test_increment();
        test_reject();
        test_tick_during_set();
        test_reject_pending();
        test_back_to_back();
        test_reset_mid_check();
`ifdef ALARM_EN
        test_alarm();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_of_day.md
# time_of_day

Time-of-day counter for the clock design: consumes the one-second tick pulse from the clock generator and maintains hours, minutes and seconds in packed BCD for the display path. Supports a validated set-time handshake and emits a one-cycle pulse on every minute boundary. An optional alarm comparator is compiled in with a macro.

## Interface
Parameters:
- HOURS_MAX, default 8'h23: BCD value of the last hour before wrap to 00.
- TICK_PENDING_DEPTH, default 1: number of ticks held while a set is being checked; only 1 is supported.

Ports:
- clk  in  1  system clock (27 MHz).
- reset  in  1  asynchronous, active-low reset.
- tick_1s  in  1  one-cycle pulse, synchronous to clk, once per second.
- set_valid  in  1  set-time request.
- set_time  in  24  BCD {hh, mm, ss}, 8 bits each.
- set_ready  out  1  high when a set request can be accepted.
- set_err  out  1  one-cycle pulse: the last set request was rejected.
- hh  out  8  BCD hours.
- mm  out  8  BCD minutes.
- ss  out  8  BCD seconds.
- min_pulse  out  1  one-cycle pulse when seconds wrap from 59 to 00.
- alarm_time  in  16  BCD {hh, mm}; present only with ALARM_EN.
- alarm_arm  in  1  level, enables the alarm; present only with ALARM_EN.
- alarm_ack  in  1  one-cycle clear; present only with ALARM_EN.
- alarm  out  1  sticky alarm flag; present only with ALARM_EN.

## Operation
- Reset values: hh = mm = ss = 8'h00; set_ready = 1; set_err = 0; min_pulse = 0; alarm = 0; pending flag = 0; FSM in RUN.
- FSM states and transitions:
  - RUN: a tick increments ss. Carry chain: ss 59→00 increments mm. mm 59→00 increments hh. hh HOURS_MAX→00.
  - RUN → CHECK on set_valid && set_ready. set_time is captured into a shadow register and set_ready drops.
  - CHECK: the shadow value is validated. Every nibble must be ≤ 9, with ss ≤ 59, mm ≤ 59 and hh ≤ HOURS_MAX.
    - Valid: hh, mm and ss load from the shadow register.
    - Invalid: time is unchanged and set_err pulses.
    - Either way the FSM returns to RUN with set_ready = 1.
- Simultaneous set accept and tick in RUN: the tick is applied in that cycle, and the later load overrides it.
- A tick arriving in CHECK sets the pending flag.
  - Valid load: the pending flag is cleared (the new time wins).
  - Rejected set: the pending tick is applied in the first RUN cycle. A new tick in that same cycle still yields only one increment, because the pending flag merges with it.
- min_pulse fires only from a tick-driven wrap, never from a load.
- Reset asserted mid-CHECK: everything returns to its reset value, and the captured set is discarded.

## Timing
- Tick sampled at cycle N → hh/mm/ss updated at N+1. min_pulse is high during N+1 only, coincident with ss = 00.
- Set accepted at N → CHECK at N+1 → new time or set_err visible at N+2, with set_ready = 1 at N+2.
- Maximum set throughput: one request every 2 cycles.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- Macro ALARM_EN.
- Defined: alarm ports are present.
  - alarm sets at the cycle after a tick makes {hh, mm, ss} equal {alarm_time, 8'h00} while alarm_arm = 1.
  - A load never triggers the alarm.
  - alarm clears on alarm_ack or on alarm_arm = 0. If set and ack coincide, set wins.
- Undefined: the alarm ports and logic are absent.

## Structure
- Package time_pkg holds:
  - the BCD byte typedef;
  - constants SEC_MAX = 8'h59 and MIN_MAX = 8'h59;
  - the FSM state enum {RUN, CHECK}.
- Sub-module bcd2_counter: a two-digit BCD mod-N counter with enable, load, max value input and carry-out. It is instantiated three times, for ss, mm and hh.

## Test plan
- Reset release, no ticks → hh:mm:ss = 00:00:00, set_ready = 1, min_pulse never asserts.
- Load 23:59:59, then one tick → 00:00:00 at the next cycle and exactly one min_pulse.
- Set 24:59:00 → set_err pulses 2 cycles after accept and time is unchanged. Set 12:5A:00 → also rejected.
- Set 10:00:00 with a tick in the accept cycle and another in CHECK → time reads 10:00:00, with no extra increment.
- Rejected set with a tick during CHECK → ss advances by exactly 1 after return to RUN.
- ALARM_EN: alarm_time = 07:30, armed, load 07:29:59, then tick → alarm = 1. alarm_ack → 0. Loading 07:30:00 directly → alarm stays 0.
